// File: rtl/poly_tone_mixer_if.sv
// Signal bundle between the piano front end (note LUT, key conditioners) and
// the polyphonic tone mixer.
interface poly_tone_mixer_if #(
    parameter int NUM_VOICES = 8,
    parameter int DIV_WIDTH  = 17,
    parameter int CW         = $clog2(NUM_VOICES + 1)
);
    logic [NUM_VOICES-1:0]           i_key;
    logic [NUM_VOICES*DIV_WIDTH-1:0] i_half_period;
    logic                            i_mono;
    logic [NUM_VOICES-1:0]           o_voice_out;
    logic [NUM_VOICES-1:0]           o_voice_active;
    logic [CW-1:0]                   o_active_count;
    logic                            o_pwm_out;

    // No valid/ready pair: inputs are levels sampled on every rising clk edge and
    // every output is a register that holds its value until the next edge.
    modport master (
        output i_key,
        output i_half_period,
        output i_mono,
        input  o_voice_out,
        input  o_voice_active,
        input  o_active_count,
        input  o_pwm_out
    );

    modport slave (
        input  i_key,
        input  i_half_period,
        input  i_mono,
        output o_voice_out,
        output o_voice_active,
        output o_active_count,
        output o_pwm_out
    );
endinterface

// File: rtl/poly_tone_mixer.sv
// Polyphonic square-wave tone generator: one divider per voice, optional
// highest-key-wins mono mode, and a frame-based PWM mixer onto one speaker pin.
module poly_tone_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int DIV_WIDTH  = 17
) (
    input  logic             clk,
    input  logic             reset,
    poly_tone_mixer_if.slave bus
);
    localparam int CW = $clog2(NUM_VOICES + 1);

    logic [NUM_VOICES-1:0] w_gate;
    logic [DIV_WIDTH-1:0]  w_hp      [NUM_VOICES];
    logic [DIV_WIDTH-1:0]  w_hp_last [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_hp_bad;
    logic [NUM_VOICES-1:0] w_mix;
    logic [CW-1:0]         w_duty_now;

    logic [NUM_VOICES-1:0] r_voice_active;
    logic [NUM_VOICES-1:0] r_voice_out;
    logic [CW-1:0]         r_active_count;
    logic [DIV_WIDTH-1:0]  r_count [NUM_VOICES];
    logic [CW-1:0]         r_sum;
    logic [CW-1:0]         r_duty;
    logic [CW-1:0]         r_fc;
    logic                  r_pwm;

    function automatic logic [CW-1:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            s = s + CW'(v[i]);
        end
        return s;
    endfunction

    // Mono mode keeps only the highest pressed key: later loop iterations overwrite.
    always_comb begin
        w_gate = '0;
        if (!bus.i_mono) begin
            w_gate = bus.i_key;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (bus.i_key[i]) begin
                    w_gate    = '0;
                    w_gate[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_hp[i]      = bus.i_half_period[i*DIV_WIDTH +: DIV_WIDTH];
            w_hp_last[i] = w_hp[i] - DIV_WIDTH'(1);
            w_hp_bad[i]  = (w_hp[i] < DIV_WIDTH'(2));
        end
    end

    // A silent voice parks at counter 0 / output 0, so key-on always starts from
    // phase 0 and the first rising edge lands HP cycles after voice_active rises.
    // The >= compare makes a shortened live HP wrap on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_voice_active <= '0;
            r_active_count <= '0;
            r_voice_out    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_voice_active <= w_gate;
            r_active_count <= popcount(w_gate);
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!r_voice_active[i] || w_hp_bad[i]) begin
                    r_count[i]     <= '0;
                    r_voice_out[i] <= 1'b0;
                end else if (r_count[i] >= w_hp_last[i]) begin
                    r_count[i]     <= '0;
                    r_voice_out[i] <= ~r_voice_out[i];
                end else begin
                    r_count[i] <= r_count[i] + DIV_WIDTH'(1);
                end
            end
        end
    end

    assign w_mix = r_voice_out & r_voice_active;

    // The frame's first slot already compares against the freshly latched sum.
    assign w_duty_now = (r_fc == '0) ? r_sum : r_duty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum  <= '0;
            r_duty <= '0;
            r_fc   <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_sum <= popcount(w_mix);
            if (r_fc == CW'(NUM_VOICES - 1)) begin
                r_fc <= '0;
            end else begin
                r_fc <= r_fc + CW'(1);
            end
            if (r_fc == '0) begin
                r_duty <= r_sum;
            end
            r_pwm <= (r_fc < w_duty_now);
        end
    end

    assign bus.o_voice_out    = r_voice_out;
    assign bus.o_voice_active = r_voice_active;
    assign bus.o_active_count = r_active_count;
    assign bus.o_pwm_out      = r_pwm;
endmodule
